// File: rtl/refresh_pkg.sv
// Shared constants, width helpers and the owed-accumulator update encoding
// for the multi-rank refresh scheduler.
package refresh_pkg;

  localparam int CLK_MHZ          = 150;
  localparam int TREFI            = 1170;  // 7.8 us at CLK_MHZ
  localparam int DEFAULT_MAX_OWED = 8;

  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 32; i++) begin
      if ((1 << result) < value) result = result + 1;
    end
    return result;
  endfunction

  // Owed count must represent 0..max_owed inclusive.
  function automatic int owed_w(input int max_owed);
    return clog2(max_owed + 1);
  endfunction

  localparam int DEFAULT_OWED_W = owed_w(DEFAULT_MAX_OWED);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    INC  = 2'd1,
    DEC  = 2'd2
  } owed_op_e;

endpackage

// File: rtl/refresh_rank_ctr.sv
// One rank: tREFI interval counter, tick pulse, owed-refresh accumulator,
// registered req/urgent flags and sticky overflow/ack errors.
module refresh_rank_ctr
  import refresh_pkg::*;
#(
  parameter int TREFI_CYCLES  = TREFI,
  parameter int CNT_W         = 24,
  parameter int MAX_OWED      = DEFAULT_MAX_OWED,
  parameter int URGENT_THRESH = 6,
  parameter int OWED_W        = owed_w(MAX_OWED),
  parameter int INIT_OFFSET   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ack,
  input  logic              err_clr,
  output logic              req,
  output logic              urgent,
  output logic              tick,
  output logic [OWED_W-1:0] owed,
  output logic              ovf_err,
  output logic              ack_err
);

  logic [CNT_W-1:0]  cnt;
  logic              expire;
  owed_op_e          op;
  logic [OWED_W-1:0] owed_nxt;
  logic              ovf_set;
  logic              ack_set;

  // A coincident expiry and ack cancel out, so neither saturation error fires.
  always_comb begin
    expire   = en && (cnt == CNT_W'(TREFI_CYCLES - 1));
    op       = HOLD;
    owed_nxt = owed;
    ovf_set  = 1'b0;
    ack_set  = 1'b0;
    if (expire && !ack)      op = INC;
    else if (!expire && ack) op = DEC;
    case (op)
      INC: begin
        if (owed == OWED_W'(MAX_OWED)) ovf_set  = 1'b1;
        else                           owed_nxt = owed + OWED_W'(1);
      end
      DEC: begin
        if (owed == '0) ack_set  = 1'b1;
        else            owed_nxt = owed - OWED_W'(1);
      end
      default: owed_nxt = owed;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= CNT_W'(INIT_OFFSET);
      tick    <= 1'b0;
      owed    <= '0;
      req     <= 1'b0;
      urgent  <= 1'b0;
      ovf_err <= 1'b0;
      ack_err <= 1'b0;
    end else begin
      if (en) begin
        cnt  <= expire ? '0 : cnt + CNT_W'(1);
        tick <= expire;
      end else begin
        tick <= 1'b0;
      end
      owed   <= owed_nxt;
      req    <= (owed_nxt != '0);
      urgent <= (owed_nxt >= OWED_W'(URGENT_THRESH));
      // Set wins over a simultaneous clear.
      if (ovf_set)      ovf_err <= 1'b1;
      else if (err_clr) ovf_err <= 1'b0;
      if (ack_set)      ack_err <= 1'b1;
      else if (err_clr) ack_err <= 1'b0;
    end
  end

endmodule

// File: rtl/refresh_scheduler.sv
// Multi-rank refresh interval scheduler: one staggered rank controller per
// rank; this level only fans vectors out to the ranks and packs results back.
module refresh_scheduler
  import refresh_pkg::*;
#(
  parameter int NUM_RANKS     = 2,
  parameter int TREFI_CYCLES  = TREFI,
  parameter int CNT_W         = 24,
  parameter int MAX_OWED      = DEFAULT_MAX_OWED,
  parameter int URGENT_THRESH = 6
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     en,
  input  logic [NUM_RANKS-1:0]                     ref_ack,
  input  logic                                     err_clr,
  output logic [NUM_RANKS-1:0]                     ref_req,
  output logic [NUM_RANKS-1:0]                     ref_urgent,
  output logic [NUM_RANKS-1:0]                     tick,
  output logic [NUM_RANKS*owed_w(MAX_OWED)-1:0]    owed_cnt,
  output logic [NUM_RANKS-1:0]                     ovf_err,
  output logic [NUM_RANKS-1:0]                     ack_err
);

  localparam int RANK_OWED_W = owed_w(MAX_OWED);

  for (genvar r = 0; r < NUM_RANKS; r++) begin : g_rank
    refresh_rank_ctr #(
      .TREFI_CYCLES (TREFI_CYCLES),
      .CNT_W        (CNT_W),
      .MAX_OWED     (MAX_OWED),
      .URGENT_THRESH(URGENT_THRESH),
      .OWED_W       (RANK_OWED_W),
      .INIT_OFFSET  (r * (TREFI_CYCLES / NUM_RANKS))
    ) u_rank (
      .clk    (clk),
      .rst_n  (rst_n),
      .en     (en),
      .ack    (ref_ack[r]),
      .err_clr(err_clr),
      .req    (ref_req[r]),
      .urgent (ref_urgent[r]),
      .tick   (tick[r]),
      .owed   (owed_cnt[r*RANK_OWED_W +: RANK_OWED_W]),
      .ovf_err(ovf_err[r]),
      .ack_err(ack_err[r])
    );
  end

endmodule

// File: tb/tb_refresh_scheduler.sv
// Directed bench for refresh_scheduler with TREFI=16, two ranks, MAX_OWED=4,
// URGENT_THRESH=3; edge numbers count enabled posedges after reset release.
module tb_refresh_scheduler;

  localparam int NR = 2;
  localparam int OW = 3;

  logic          clk;
  logic          rst_n;
  logic          en;
  logic [NR-1:0] ref_ack;
  logic          err_clr;
  logic [NR-1:0] ref_req;
  logic [NR-1:0] ref_urgent;
  logic [NR-1:0] tick;
  logic [NR*OW-1:0] owed_cnt;
  logic [NR-1:0] ovf_err;
  logic [NR-1:0] ack_err;

  int errors;
  int checks;

  refresh_scheduler #(
    .NUM_RANKS    (2),
    .TREFI_CYCLES (16),
    .CNT_W        (8),
    .MAX_OWED     (4),
    .URGENT_THRESH(3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .ref_ack   (ref_ack),
    .err_clr   (err_clr),
    .ref_req   (ref_req),
    .ref_urgent(ref_urgent),
    .tick      (tick),
    .owed_cnt  (owed_cnt),
    .ovf_err   (ovf_err),
    .ack_err   (ack_err)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    ref_ack = '0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    en      = 1'b1;
    ref_ack = '0;
    err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({ref_req, ref_urgent, tick, owed_cnt, ovf_err, ack_err} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got %h expected 0",
               {ref_req, ref_urgent, tick, owed_cnt, ovf_err, ack_err});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_tick_stagger();
    logic [NR-1:0] exp_tick;
    logic [OW-1:0] exp_o0, exp_o1;
    apply_reset();
    exp_o0 = '0;
    exp_o1 = '0;
    for (int e = 1; e <= 40; e++) begin
      step();
      exp_tick[0] = (e == 16) || (e == 32);
      exp_tick[1] = (e == 8) || (e == 24) || (e == 40);
      if (exp_tick[0]) exp_o0 = exp_o0 + 1'b1;
      if (exp_tick[1]) exp_o1 = exp_o1 + 1'b1;
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL stagger_tick e=%0d: got %b expected %b", e, tick, exp_tick);
      end
      checks++;
      if (owed_cnt !== {exp_o1, exp_o0}) begin
        errors++;
        $display("FAIL stagger_owed e=%0d: got %h expected %h", e, owed_cnt, {exp_o1, exp_o0});
      end
      checks++;
      if (ref_req !== {exp_o1 != 0, exp_o0 != 0}) begin
        errors++;
        $display("FAIL stagger_req e=%0d: got %b expected %b", e, ref_req,
                 {exp_o1 != 0, exp_o0 != 0});
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset();
    repeat (48) step();
    checks++;
    if (owed_cnt[2:0] !== 3'd3 || ref_urgent[0] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_owed3: got owed=%0d urgent=%b expected 3/1", owed_cnt[2:0], ref_urgent[0]);
    end
    repeat (16) step();
    checks++;
    if (owed_cnt[2:0] !== 3'd4 || ref_urgent[0] !== 1'b1 || ovf_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_owed4: got owed=%0d urgent=%b ovf=%b expected 4/1/0",
               owed_cnt[2:0], ref_urgent[0], ovf_err[0]);
    end
    repeat (16) step();
    checks++;
    if (owed_cnt[2:0] !== 3'd4 || ovf_err !== 2'b11) begin
      errors++;
      $display("FAIL ovf_sat: got owed=%0d ovf=%b expected 4/11", owed_cnt[2:0], ovf_err);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if (ovf_err !== 2'b00) begin
      errors++;
      $display("FAIL ovf_clear: got %b expected 00", ovf_err);
    end
  endtask

  task automatic test_ack();
    apply_reset();
    repeat (32) step();
    checks++;
    if (owed_cnt[2:0] !== 3'd2) begin
      errors++;
      $display("FAIL ack_pre: got owed=%0d expected 2", owed_cnt[2:0]);
    end
    ref_ack = 2'b01;
    step();
    checks++;
    if (owed_cnt[2:0] !== 3'd1 || ref_req[0] !== 1'b1) begin
      errors++;
      $display("FAIL ack_first: got owed=%0d req=%b expected 1/1", owed_cnt[2:0], ref_req[0]);
    end
    step();
    checks++;
    if (owed_cnt[2:0] !== 3'd0 || ref_req[0] !== 1'b0 || ack_err[0] !== 1'b0) begin
      errors++;
      $display("FAIL ack_second: got owed=%0d req=%b err=%b expected 0/0/0",
               owed_cnt[2:0], ref_req[0], ack_err[0]);
    end
    step();
    ref_ack = 2'b00;
    checks++;
    if (owed_cnt[2:0] !== 3'd0 || ack_err !== 2'b01) begin
      errors++;
      $display("FAIL ack_underflow: got owed=%0d ack_err=%b expected 0/01", owed_cnt[2:0], ack_err);
    end
  endtask

  task automatic test_ack_on_expiry();
    apply_reset();
    repeat (15) step();
    ref_ack = 2'b01;
    step();
    ref_ack = 2'b00;
    checks++;
    if (tick[0] !== 1'b1 || owed_cnt[2:0] !== 3'd0 || ack_err[0] !== 1'b0 || ref_req[0] !== 1'b0) begin
      errors++;
      $display("FAIL ack_on_expiry: got tick=%b owed=%0d err=%b req=%b expected 1/0/0/0",
               tick[0], owed_cnt[2:0], ack_err[0], ref_req[0]);
    end
  endtask

  task automatic test_enable_hold();
    logic [NR-1:0] exp_tick;
    apply_reset();
    repeat (10) step();
    for (int e = 11; e <= 30; e++) begin
      en      = !(e >= 11 && e <= 15);
      ref_ack = (e == 12) ? 2'b10 : 2'b00;
      step();
      exp_tick[0] = (e == 21);
      exp_tick[1] = (e == 29);
      checks++;
      if (tick !== exp_tick) begin
        errors++;
        $display("FAIL en_hold_tick e=%0d: got %b expected %b", e, tick, exp_tick);
      end
      if (e == 12) begin
        checks++;
        if (owed_cnt[5:3] !== 3'd0 || ack_err[1] !== 1'b0) begin
          errors++;
          $display("FAIL en_hold_ack: got owed1=%0d err=%b expected 0/0", owed_cnt[5:3], ack_err[1]);
        end
      end
    end
    en      = 1'b1;
    ref_ack = '0;
  endtask

  task automatic test_async_reset();
    logic exp_t1;
    apply_reset();
    repeat (40) step();
    checks++;
    if (owed_cnt[5:3] !== 3'd3) begin
      errors++;
      $display("FAIL arst_pre: got owed1=%0d expected 3", owed_cnt[5:3]);
    end
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ref_req, ref_urgent, tick, owed_cnt, ovf_err, ack_err} !== '0) begin
      errors++;
      $display("FAIL arst_outputs: got %h expected 0",
               {ref_req, ref_urgent, tick, owed_cnt, ovf_err, ack_err});
    end
    rst_n = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step();
      exp_t1 = (e == 8);
      checks++;
      if (tick[1] !== exp_t1 || tick[0] !== 1'b0) begin
        errors++;
        $display("FAIL arst_stagger e=%0d: got %b expected %b", e, tick, {exp_t1, 1'b0});
      end
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_tick_stagger();
    test_overflow();
    test_ack();
    test_ack_on_expiry();
    test_enable_hold();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
